wash_ctrl_seq: RTL
==================

// Module: wash_ctrl_seq
// PURPOSE
//  Parametrised washing-machine program sequencer. Runs cyindex wash/drain/rinse/drain
//  rounds, then a final spin. Each phase has a 2-digit BCD countdown timed by an internal
//  1 s tick prescaler. Adds pause/resume, a door interlock and a done flag. Outputs feed
//  the board 7-segment/LED display stage.
// PARAMETERS
//  TICK_DIV  50_000_000  clk cycles per 1 s tick (sim: 4)
//  CW        4           width of round count (cyindex, rounds_left)
//  T_WASH    8'h60       wash duration, BCD seconds (00-99)
//  T_DRAIN   8'h05       drain duration, BCD
//  T_RINSE   8'h60       rinse duration, BCD
//  T_SPIN    8'h10       final spin duration, BCD
//  BLINK_DIV 1           ticks per warning-LED toggle
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous reset, active-low
//  start        in   1   level; rising edge in IDLE/DONE launches program
//  pause        in   1   level; 1 = hold timer and outputs frozen
//  door_open    in   1   level; 1 = interlock active
//  cyindex      in   CW  number of rounds; sampled on start edge
//  status       out  3   one-hot phase: 100 wash, 010 drain, 001 rinse, 000 idle/done/spin
//  spin         out  1   1 during SPIN
//  time_bcd     out  8   remaining seconds of current phase, BCD
//  rounds_left  out  CW  rounds not yet completed, including current
//  busy         out  1   1 in any state except IDLE/DONE
//  done         out  1   1 in DONE
//  warning      out  1   blinks at BLINK_DIV ticks when start edge seen with cyindex==0, or door_open while busy
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; all outputs 0; prescaler, blink and timer cleared.
//  tick: 1-clk pulse every TICK_DIV clks; prescaler restarts on start edge for an exact first second.
//  FSM: IDLE/DONE -(start rise, cyindex!=0, !door_open)-> WASH;
//   WASH->DRAIN_A->RINSE->DRAIN_B; then DRAIN_B->WASH if rounds_left>1, else ->SPIN; SPIN->DONE.
//  Phase entry loads time_bcd with that phase's T_*, in the same clk as the transition.
//  Countdown: on tick with !pause && !door_open: units>0: units-1; else tens-1 and units=9.
//   Time 00 on a tick ends the phase, so each phase lasts T+1 ticks (shows T..00).
//  rounds_left: loaded with cyindex on launch; decremented on the DRAIN_B->WASH/SPIN transition.
//   At SPIN it is 0. No wrap: never decrements below 0.
//  start edge with cyindex==0: stay in IDLE, warning blinks until start falls.
//  start edge while busy: ignored. start level low mid-program: no effect (not an abort).
//  door_open while busy: timer frozen, status forced 000, spin 0, warning blinks.
//   On release, the phase resumes with status restored and the remaining time unchanged.
//  pause: timer frozen and status held. pause+door_open: door rules apply.
//  Tick coincident with pause/door assert: the tick is discarded.
//  done stays 1 until the next valid start edge, which clears it in the launch clk.
//  Reset mid-program: immediate IDLE, no resume.
//  The BCD decrement never sees a non-BCD value; T_* are required to be legal BCD.
// STRUCTURE
//  Package wash_pkg: state encodings (IDLE, WASH, DRAIN_A, RINSE, DRAIN_B, SPIN, DONE),
//   status one-hot constants, and the BCD decrement function.
//  Sub-module tick_gen: parameter DIV; inputs clk, rst_n, clr; output tick. It is also
//   reused by the display scan logic.
//  Top level: FSM, BCD timer, round counter, warning blink. All logic is single clk domain.
// TESTING (TICK_DIV=4, T_WASH=8'h03, T_DRAIN=8'h01, T_RINSE=8'h02, T_SPIN=8'h01)
//  1. cyindex=2, start rise -> status 100/010/001/010 x2, then spin, then done=1 after
//     (4+2+3+2)*2+2=24 ticks; rounds_left goes 2->1->0.
//  2. cyindex=0, start rise -> stays IDLE, busy=0, warning toggles every tick until start=0.
//  3. pause=1 for 10 ticks at WASH time_bcd=02 -> time stays 02 and status stays 100;
//     release -> 01 on the next tick.
//  4. door_open=1 mid-RINSE -> status 000, warning blinks, time frozen;
//     door_open=0 -> status 001, same time.
//  5. rst_n=0 mid-DRAIN_B, asserted asynchronously between clk edges -> outputs 0 before
//     the next clk edge; rst_n=1 -> IDLE; a fresh start reloads cyindex.
//  6. BCD wrap: T_WASH=8'h10 -> time_bcd goes 10, 09, 08 (never 0F).

Source files
------------

// File: rtl/wash_pkg.sv
// Shared types for the washing-machine sequencer: FSM states, one-hot phase
// codes and the two-digit BCD countdown step.
package wash_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WASH,
        S_DRAIN_A,
        S_RINSE,
        S_DRAIN_B,
        S_SPIN,
        S_DONE
    } state_e;

    localparam logic [2:0] ST_WASH  = 3'b100;
    localparam logic [2:0] ST_DRAIN = 3'b010;
    localparam logic [2:0] ST_RINSE = 3'b001;
    localparam logic [2:0] ST_NONE  = 3'b000;

    // Borrow from the tens digit when the units digit is already zero.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] != 4'd0)
            r = {v[7:4], v[3:0] - 4'd1};
        else if (v[7:4] != 4'd0)
            r = {v[7:4] - 4'd1, 4'd9};
        else
            r = 8'h00;
        return r;
    endfunction

    function automatic logic [2:0] phase_status(input state_e s);
        logic [2:0] r;
        case (s)
            S_WASH:    r = ST_WASH;
            S_DRAIN_A: r = ST_DRAIN;
            S_RINSE:   r = ST_RINSE;
            S_DRAIN_B: r = ST_DRAIN;
            default:   r = ST_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-clock pulse every DIV clocks;
// clr restarts the count so the next pulse lands exactly DIV clocks later.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || tick)
            cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/wash_ctrl_seq.sv
// Washing-machine program sequencer: wash/drain/rinse/drain rounds then spin,
// each phase counted down in BCD seconds, with pause, door interlock and warning blink.
module wash_ctrl_seq
    import wash_pkg::*;
#(
    parameter int         TICK_DIV  = 50_000_000,
    parameter int         CW        = 4,
    parameter logic [7:0] T_WASH    = 8'h60,
    parameter logic [7:0] T_DRAIN   = 8'h05,
    parameter logic [7:0] T_RINSE   = 8'h60,
    parameter logic [7:0] T_SPIN    = 8'h10,
    parameter int         BLINK_DIV = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          pause,
    input  logic          door_open,
    input  logic [CW-1:0] cyindex,
    output logic [2:0]    status,
    output logic          spin,
    output logic [7:0]    time_bcd,
    output logic [CW-1:0] rounds_left,
    output logic          busy,
    output logic          done,
    output logic          warning
);

    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLAST = BW'(BLINK_DIV - 1);
    localparam logic [CW-1:0] ONE   = CW'(1);

    state_e        state_q, state_d;
    logic [7:0]    time_q, time_d;
    logic [CW-1:0] rounds_q, rounds_d;
    logic          start_q;
    logic          zero_req_q, zero_req_d;
    logic          warn_q, warn_d;
    logic [BW-1:0] blink_q, blink_d;

    logic tick, start_rise, idle_like, launch, run, warn_cond;

    assign start_rise = start & ~start_q;
    assign idle_like  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign launch     = idle_like && start_rise && (cyindex != '0) && !door_open;
    assign run        = tick && !idle_like && !pause && !door_open;
    assign warn_cond  = zero_req_q || (!idle_like && door_open);

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (launch),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        time_d   = time_q;
        rounds_d = rounds_q;
        if (launch) begin
            state_d  = S_WASH;
            time_d   = T_WASH;
            rounds_d = cyindex;
        end else if (run) begin
            if (time_q != 8'h00) begin
                time_d = bcd_dec(time_q);
            end else begin
                case (state_q)
                    S_WASH:    begin state_d = S_DRAIN_A; time_d = T_DRAIN; end
                    S_DRAIN_A: begin state_d = S_RINSE;   time_d = T_RINSE; end
                    S_RINSE:   begin state_d = S_DRAIN_B; time_d = T_DRAIN; end
                    S_DRAIN_B: begin
                        if (rounds_q > ONE) begin
                            state_d = S_WASH;
                            time_d  = T_WASH;
                        end else begin
                            state_d = S_SPIN;
                            time_d  = T_SPIN;
                        end
                        if (rounds_q != '0)
                            rounds_d = rounds_q - ONE;
                    end
                    S_SPIN:    begin state_d = S_DONE;    time_d = 8'h00; end
                    default:   ;
                endcase
            end
        end
    end

    // A zero-round request keeps warning alive only while start is held high.
    always_comb begin
        zero_req_d = zero_req_q;
        if (!start)
            zero_req_d = 1'b0;
        else if (idle_like && start_rise && (cyindex == '0))
            zero_req_d = 1'b1;

        warn_d  = warn_q;
        blink_d = blink_q;
        if (!warn_cond) begin
            warn_d  = 1'b0;
            blink_d = '0;
        end else if (tick) begin
            if (blink_q == BLAST) begin
                blink_d = '0;
                warn_d  = ~warn_q;
            end else begin
                blink_d = blink_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            time_q     <= 8'h00;
            rounds_q   <= '0;
            start_q    <= 1'b0;
            zero_req_q <= 1'b0;
            warn_q     <= 1'b0;
            blink_q    <= '0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            rounds_q   <= rounds_d;
            start_q    <= start;
            zero_req_q <= zero_req_d;
            warn_q     <= warn_d;
            blink_q    <= blink_d;
        end
    end

    assign status      = (door_open && !idle_like) ? ST_NONE : phase_status(state_q);
    assign spin        = (state_q == S_SPIN) && !door_open;
    assign time_bcd    = time_q;
    assign rounds_left = rounds_q;
    assign busy        = !idle_like;
    assign done        = (state_q == S_DONE);
    assign warning     = warn_q;

endmodule
